// File: rtl/ps2_pkg.sv
// ps2_pkg: shared scan codes, state encodings and frame builder for the PS/2 autotyper
package ps2_pkg;

   localparam logic [7:0] PS2_BREAK     = 8'hF0;
   localparam logic [7:0] PS2_KEY_B     = 8'h32;
   localparam logic [7:0] PS2_KEY_C     = 8'h21;
   localparam logic [7:0] PS2_KEY_ENTER = 8'h5A;

   // gap counter must hold KEY_GAP-1 (2.5M at 25 MHz needs 22 bits)
   localparam int GAP_W  = 24;
   localparam int HALF_W = 16;

   typedef enum logic [1:0] {TX_IDLE, TX_SHIFT_HI, TX_SHIFT_LO} tx_state_t;

   typedef enum logic [2:0] {SEQ_IDLE, SEQ_ARM, SEQ_FRAME, SEQ_BYTE_WAIT, SEQ_KEY_WAIT} seq_state_t;

   // device-to-host frame, bit 0 goes out first: start, data LSB first, odd parity, stop
   function automatic logic [10:0] ps2_frame(input logic [7:0] code);
      return {1'b1, ~^code, code, 1'b0};
   endfunction

endpackage

// File: rtl/ps2_frame_tx.sv
// ps2_frame_tx: shifts one 11-bit PS/2 frame out on a clock/data pair
module ps2_frame_tx
   import ps2_pkg::*;
#(
   parameter int unsigned CLK_HALF = 1000
)(
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] tx_byte_i,
   input  logic       send_i,
   output logic       ps2clk_o,
   output logic       ps2data_o,
   output logic       frame_done_o
);

   localparam logic [HALF_W-1:0] HALF_LOAD = HALF_W'(CLK_HALF - 1);

   tx_state_t         state_q, state_d;
   logic [HALF_W-1:0] cnt_q, cnt_d;
   logic [3:0]        bitcnt_q, bitcnt_d;
   logic [10:0]       shreg_q, shreg_d;
   logic              clk_q, clk_d;

   // data line is the shift register LSB, so it only moves when a new bit is presented
   assign ps2clk_o  = clk_q;
   assign ps2data_o = shreg_q[0];

   // state, half-period counter, bit counter and line registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= TX_IDLE;
         cnt_q    <= '0;
         bitcnt_q <= '0;
         shreg_q  <= '1;
         clk_q    <= 1'b1;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         bitcnt_q <= bitcnt_d;
         shreg_q  <= shreg_d;
         clk_q    <= clk_d;
      end
   end

   // high half presents a bit, low half lets the host sample it; ones shift in behind the frame
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      bitcnt_d     = bitcnt_q;
      shreg_d      = shreg_q;
      clk_d        = clk_q;
      frame_done_o = 1'b0;
      case (state_q)
         TX_IDLE: if (send_i) begin
            shreg_d  = ps2_frame(tx_byte_i);
            bitcnt_d = '0;
            cnt_d    = HALF_LOAD;
            clk_d    = 1'b1;
            state_d  = TX_SHIFT_HI;
         end
         TX_SHIFT_HI: if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
         else begin
            cnt_d   = HALF_LOAD;
            clk_d   = 1'b0;
            state_d = TX_SHIFT_LO;
         end
         TX_SHIFT_LO: if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
         else if (bitcnt_q < 4'd10) begin
            bitcnt_d = bitcnt_q + 1'b1;
            shreg_d  = {1'b1, shreg_q[10:1]};
            cnt_d    = HALF_LOAD;
            clk_d    = 1'b1;
            state_d  = TX_SHIFT_HI;
         end else begin
            frame_done_o = 1'b1;
            shreg_d      = '1;
            clk_d        = 1'b1;
            state_d      = TX_IDLE;
         end
         default: state_d = TX_IDLE;
      endcase
   end

endmodule

// File: rtl/ps2_autotype.sv
// ps2_autotype: replays a scripted list of set-2 keys as make/break PS/2 frames
module ps2_autotype
   import ps2_pkg::*;
#(
   parameter int unsigned  CLK_HALF   = 1000,
   parameter int unsigned  BYTE_GAP   = 2500,
   parameter int unsigned  KEY_GAP    = 2500000,
   parameter int unsigned  SCRIPT_LEN = 5,
   parameter logic [127:0] SCRIPT     = {88'h0, PS2_KEY_ENTER, PS2_KEY_ENTER, PS2_KEY_ENTER, PS2_KEY_C, PS2_KEY_B}
)(
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   output logic       ps2clk,
   output logic       ps2data,
   output logic       busy,
   output logic       done,
   output logic [3:0] key_index
);

   localparam logic [GAP_W-1:0] BYTE_LOAD = GAP_W'(BYTE_GAP - 1);
   localparam logic [GAP_W-1:0] KEY_LOAD  = GAP_W'(KEY_GAP - 1);
   localparam logic [3:0]       LAST_KEY  = 4'(SCRIPT_LEN - 1);

   seq_state_t       state_q, state_d;
   logic [GAP_W-1:0] cnt_q, cnt_d;
   logic [1:0]       phase_q, phase_d;
   logic [3:0]       key_q, key_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             send;
   logic             frame_done;
   logic [7:0]       tx_byte;

   assign busy      = busy_q;
   assign done      = done_q;
   assign key_index = key_q;

   // byte is chosen from the upcoming phase/key so it is valid on the cycle send fires
   assign tx_byte = (phase_d == 2'd1) ? PS2_BREAK : SCRIPT[{key_d, 3'b000} +: 8];

   // sequencer state, shared gap counter, phase/key position and status flags
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= SEQ_IDLE;
         cnt_q   <= '0;
         phase_q <= '0;
         key_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
         key_q   <= key_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // ARM adds the one cycle between sampling start and the first start bit; gaps end with send
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      phase_d = phase_q;
      key_d   = key_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      send    = 1'b0;
      case (state_q)
         SEQ_IDLE: if (start) begin
            phase_d = '0;
            key_d   = '0;
            state_d = SEQ_ARM;
         end
         SEQ_ARM: begin
            send    = 1'b1;
            busy_d  = 1'b1;
            state_d = SEQ_FRAME;
         end
         SEQ_FRAME: if (frame_done) begin
            cnt_d   = (phase_q < 2'd2) ? BYTE_LOAD : KEY_LOAD;
            state_d = (phase_q < 2'd2) ? SEQ_BYTE_WAIT : SEQ_KEY_WAIT;
         end
         SEQ_BYTE_WAIT: if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
         else begin
            phase_d = phase_q + 1'b1;
            send    = 1'b1;
            state_d = SEQ_FRAME;
         end
         SEQ_KEY_WAIT: if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
         else if (key_q == LAST_KEY) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = SEQ_IDLE;
         end else begin
            key_d   = key_q + 1'b1;
            phase_d = '0;
            send    = 1'b1;
            state_d = SEQ_FRAME;
         end
         default: state_d = SEQ_IDLE;
      endcase
   end

   ps2_frame_tx #(.CLK_HALF(CLK_HALF)) u_tx (
      .clk          (clk),
      .reset        (reset),
      .tx_byte_i    (tx_byte),
      .send_i       (send),
      .ps2clk_o     (ps2clk),
      .ps2data_o    (ps2data),
      .frame_done_o (frame_done)
   );

endmodule

// File: tb/tb_ps2_autotype.sv
// tb_ps2_autotype: PS/2 receiver model decoding three autotyper instances
module tb_ps2_autotype;

   localparam int CH = 4, BG = 8, KG = 16;
   localparam int KEY_CYC = 66 * CH + 2 * BG + KG;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [2:0] st = '0;
   logic [2:0] pc, pd, bz, dn;
   logic [3:0] ki [3];
   int         sel = 0;
   logic       s_clk, s_data, s_busy, s_done;
   logic [3:0] s_ki;

   int         checks = 0, errors = 0;
   logic [10:0] rx [$];
   logic [3:0]  rx_key [$];
   logic [7:0]  exp_keys [$];
   int          busy_rise, busy_fall, done_at, done_cnt;
   logic        first_data;

   always #5 clk = ~clk;

   assign s_clk  = pc[sel];
   assign s_data = pd[sel];
   assign s_busy = bz[sel];
   assign s_done = dn[sel];
   assign s_ki   = ki[sel];

   ps2_autotype #(.CLK_HALF(CH), .BYTE_GAP(BG), .KEY_GAP(KG)) u_def (
      .clk(clk), .reset(reset), .start(st[0]), .ps2clk(pc[0]), .ps2data(pd[0]),
      .busy(bz[0]), .done(dn[0]), .key_index(ki[0]));

   ps2_autotype #(.CLK_HALF(CH), .BYTE_GAP(BG), .KEY_GAP(KG), .SCRIPT_LEN(1), .SCRIPT(128'h32)) u_one (
      .clk(clk), .reset(reset), .start(st[1]), .ps2clk(pc[1]), .ps2data(pd[1]),
      .busy(bz[1]), .done(dn[1]), .key_index(ki[1]));

   ps2_autotype #(.CLK_HALF(CH), .BYTE_GAP(BG), .KEY_GAP(KG), .SCRIPT_LEN(3), .SCRIPT(128'h01FF00)) u_par (
      .clk(clk), .reset(reset), .start(st[2]), .ps2clk(pc[2]), .ps2data(pd[2]),
      .busy(bz[2]), .done(dn[2]), .key_index(ki[2]));

   // expected n-th frame of the stream: each key gives code, F0, code; parity makes the ones count odd
   function automatic logic [10:0] model_frame(input int n);
      int code, ones;
      code = (n % 3 == 1) ? 'hF0 : int'(exp_keys[n / 3]);
      ones = 0;
      for (int i = 0; i < 8; i++) ones += (code >> i) & 1;
      return 11'(1024 + ((ones % 2 == 0) ? 512 : 0) + code * 2);
   endfunction

   task automatic pulse(input int which);
      @(negedge clk) st[which] = 1'b1;
      @(negedge clk) st[which] = 1'b0;
   endtask

   // receiver: shifts in data on each falling ps2clk, logs busy/done timing
   task automatic capture(input int max_cyc);
      int nb;
      logic [10:0] cur;
      logic prev, pb;
      nb = 0; cur = '0; prev = s_clk; pb = s_busy;
      rx.delete(); rx_key.delete();
      busy_rise = -1; busy_fall = -1; done_at = -1; done_cnt = 0;
      for (int c = 0; c < max_cyc; c++) begin
         @(negedge clk);
         if (c == 0) first_data = s_data;
         if (prev && !s_clk) begin
            cur[nb] = s_data;
            nb++;
            if (nb == 11) begin rx.push_back(cur); rx_key.push_back(s_ki); nb = 0; end
         end
         if (s_busy && !pb && busy_rise < 0) busy_rise = c;
         if (!s_busy && pb && busy_fall < 0) busy_fall = c;
         if (s_done) begin done_cnt++; done_at = c; end
         prev = s_clk; pb = s_busy;
         if (done_cnt > 0 && c >= done_at + 30) break;
      end
   endtask

   task automatic test_reset;
      int bad;
      repeat ($urandom_range(3, 10)) @(negedge clk);
      checks++;
      if (pc !== 3'b111 || pd !== 3'b111 || bz !== 3'b000 || dn !== 3'b000 || ki[0] !== 4'd0) begin
         errors++; $display("FAIL reset_values: clk=%b data=%b busy=%b done=%b ki=%0d want 111 111 000 000 0", pc, pd, bz, dn, ki[0]);
      end
      reset = 1'b0;
      for (int r = 0; r < 3; r++) begin
         repeat ($urandom_range(1, 50)) @(negedge clk);
         reset = 1'b1;
         #1;
         checks++;
         if (pc !== 3'b111 || pd !== 3'b111 || bz !== 3'b000) begin
            errors++; $display("FAIL reset_pulse%0d: clk=%b data=%b busy=%b want 111 111 000", r, pc, pd, bz);
         end
         @(negedge clk) reset = 1'b0;
      end
      bad = 0;
      repeat (1000) begin
         @(negedge clk);
         if (pc !== 3'b111 || pd !== 3'b111 || bz !== 3'b000 || dn !== 3'b000) bad++;
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL idle_quiet: %0d active cycles, want 0", bad); end
   endtask

   task automatic test_single_key;
      sel = 1;
      exp_keys = '{8'h32};
      pulse(1);
      checks++;
      if (bz[1] !== 1'b0 || pd[1] !== 1'b1) begin
         errors++; $display("FAIL single_early: busy=%b data=%b want 0 1", bz[1], pd[1]);
      end
      capture(600);
      checks++;
      if (busy_rise !== 0 || first_data !== 1'b0) begin
         errors++; $display("FAIL single_latency: busy_rise=%0d first_data=%b want 0 0", busy_rise, first_data);
      end
      checks++;
      if (rx.size() != 3) begin errors++; $display("FAIL single_count: got %0d frames want 3", rx.size()); end
      for (int i = 0; i < rx.size() && i < 3; i++) begin
         checks++;
         if (rx[i] !== model_frame(i)) begin
            errors++; $display("FAIL single_frame%0d: got %b want %b", i, rx[i], model_frame(i));
         end
      end
      checks++;
      if (done_cnt != 1 || done_at - busy_rise != KEY_CYC || busy_fall != done_at) begin
         errors++; $display("FAIL single_done: count=%0d dur=%0d busy_fall=%0d want 1 %0d %0d", done_cnt, done_at - busy_rise, busy_fall, KEY_CYC, done_at);
      end
   endtask

   task automatic test_start_while_busy;
      sel = 1;
      exp_keys = '{8'h32};
      pulse(1);
      fork
         capture(600);
         repeat (4) begin
            repeat ($urandom_range(5, 40)) @(negedge clk);
            pulse(1);
         end
      join
      checks++;
      if (rx.size() != 3) begin errors++; $display("FAIL busy_start_count: got %0d frames want 3", rx.size()); end
      for (int i = 0; i < rx.size() && i < 3; i++) begin
         checks++;
         if (rx[i] !== model_frame(i)) begin
            errors++; $display("FAIL busy_start_frame%0d: got %b want %b", i, rx[i], model_frame(i));
         end
      end
      checks++;
      if (done_cnt != 1 || done_at - busy_rise != KEY_CYC || bz[1] !== 1'b0) begin
         errors++; $display("FAIL busy_start_done: count=%0d dur=%0d busy=%b want 1 %0d 0", done_cnt, done_at - busy_rise, bz[1], KEY_CYC);
      end
   endtask

   task automatic test_default_script;
      sel = 0;
      exp_keys = '{8'h32, 8'h21, 8'h5A, 8'h5A, 8'h5A};
      repeat ($urandom_range(1, 20)) @(negedge clk);
      pulse(0);
      capture(3000);
      checks++;
      if (rx.size() != 15) begin errors++; $display("FAIL script_count: got %0d frames want 15", rx.size()); end
      for (int i = 0; i < rx.size() && i < 15; i++) begin
         checks++;
         if (rx[i] !== model_frame(i) || rx_key[i] !== 4'(i / 3)) begin
            errors++; $display("FAIL script_frame%0d: got %b key %0d want %b key %0d", i, rx[i], rx_key[i], model_frame(i), i / 3);
         end
      end
      checks++;
      if (done_cnt != 1 || done_at - busy_rise != 5 * KEY_CYC || busy_fall != done_at) begin
         errors++; $display("FAIL script_done: count=%0d dur=%0d want 1 %0d", done_cnt, done_at - busy_rise, 5 * KEY_CYC);
      end
   endtask

   task automatic test_parity;
      sel = 2;
      exp_keys = '{8'h00, 8'hFF, 8'h01};
      pulse(2);
      capture(2000);
      checks++;
      if (rx.size() != 9) begin errors++; $display("FAIL parity_count: got %0d frames want 9", rx.size()); end
      if (rx.size() >= 7) begin
         checks++;
         if (rx[0][9] !== 1'b1 || rx[3][9] !== 1'b1 || rx[6][9] !== 1'b0) begin
            errors++; $display("FAIL parity_bits: got %b%b%b want 110", rx[0][9], rx[3][9], rx[6][9]);
         end
      end
      for (int i = 0; i < rx.size() && i < 9; i++) begin
         checks++;
         if (rx[i] !== model_frame(i)) begin
            errors++; $display("FAIL parity_frame%0d: got %b want %b", i, rx[i], model_frame(i));
         end
      end
      checks++;
      if (done_cnt != 1 || done_at - busy_rise != 3 * KEY_CYC) begin
         errors++; $display("FAIL parity_done: count=%0d dur=%0d want 1 %0d", done_cnt, done_at - busy_rise, 3 * KEY_CYC);
      end
   endtask

   task automatic test_reset_mid;
      int edges;
      logic prev;
      sel = 0;
      exp_keys = '{8'h32, 8'h21, 8'h5A, 8'h5A, 8'h5A};
      pulse(0);
      edges = 0; prev = pc[0];
      for (int c = 0; c < 2000 && edges < 17; c++) begin
         @(negedge clk);
         if (prev && !pc[0]) edges++;
         prev = pc[0];
      end
      checks++;
      if (edges != 17) begin errors++; $display("FAIL mid_reach: got %0d falling edges want 17", edges); end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      checks++;
      if (pc[0] !== 1'b0) begin errors++; $display("FAIL mid_low: ps2clk=%b want 0", pc[0]); end
      reset = 1'b1;
      #1;
      checks++;
      if (pc[0] !== 1'b1 || pd[0] !== 1'b1 || bz[0] !== 1'b0 || ki[0] !== 4'd0) begin
         errors++; $display("FAIL mid_reset: clk=%b data=%b busy=%b ki=%0d want 1 1 0 0", pc[0], pd[0], bz[0], ki[0]);
      end
      @(negedge clk) reset = 1'b0;
      repeat ($urandom_range(2, 30)) @(negedge clk);
      pulse(0);
      capture(3000);
      checks++;
      if (rx.size() != 15) begin errors++; $display("FAIL replay_count: got %0d frames want 15", rx.size()); end
      for (int i = 0; i < rx.size() && i < 15; i++) begin
         checks++;
         if (rx[i] !== model_frame(i)) begin
            errors++; $display("FAIL replay_frame%0d: got %b want %b", i, rx[i], model_frame(i));
         end
      end
      checks++;
      if (done_cnt != 1 || done_at - busy_rise != 5 * KEY_CYC) begin
         errors++; $display("FAIL replay_done: count=%0d dur=%0d want 1 %0d", done_cnt, done_at - busy_rise, 5 * KEY_CYC);
      end
   endtask

   initial begin
      test_reset;
      test_single_key;
      test_start_while_busy;
      test_default_script;
      test_parity;
      test_reset_mid;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
